// File: rtl/gcd_ctrl_if.sv
// Handshake, datapath-control and status bundle between gcd_ctrl and its environment.
// master = controller side, slave = datapath / producer / consumer side.
interface gcd_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             operand_val;
  logic             operand_rdy;
  logic             result_val;
  logic             result_rdy;
  logic             A_en;
  logic             B_en;
  logic [1:0]       A_sel;
  logic             B_sel;
  logic             B_zero;
  logic             A_lt_B;
  logic             busy;
  logic [CNT_W-1:0] cycle_count;
  logic             result_err;

  modport master (
    input  operand_val, result_rdy, B_zero, A_lt_B,
    output operand_rdy, result_val, A_en, B_en, A_sel, B_sel,
           busy, cycle_count, result_err
  );

  modport slave (
    output operand_val, result_rdy, B_zero, A_lt_B,
    input  operand_rdy, result_val, A_en, B_en, A_sel, B_sel,
           busy, cycle_count, result_err
  );
endinterface

// File: rtl/gcd_ctrl.sv
// Subtract-and-swap GCD controller: sequences the A/B datapath from its B_zero/A_lt_B flags.
// Optional GCD_CTRL_TIMEOUT_EN forces termination (result_err=1) after MAX_ITER CALC cycles.
module gcd_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 1024
) (
  input  logic       clk,
  input  logic       reset,
  gcd_ctrl_if.master bus
);
  // state  | meaning
  // IDLE   | ready for an operand pair
  // CALC   | swap / subtract until B reaches zero
  // DONE   | result_data valid, waiting for result_rdy
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             natural_end;
  logic             force_end;

  if (MAX_ITER < 1 || MAX_ITER >= (2 ** CNT_W)) begin : g_bad_max_iter
    $error("gcd_ctrl: MAX_ITER out of range for CNT_W");
  end

  assign natural_end = bus.B_zero & ~bus.A_lt_B;

`ifdef GCD_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_ITER - 1);
  assign force_end = (cnt_q == LAST_CNT) && !natural_end;
`else
  assign force_end = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    bus.operand_rdy = 1'b0;
    bus.result_val  = 1'b0;
    bus.A_en        = 1'b0;
    bus.B_en        = 1'b0;
    bus.A_sel       = 2'd0;
    bus.B_sel       = 1'b0;
    bus.busy        = (state_q != S_IDLE);
    bus.cycle_count = cnt_q;
    bus.result_err  = err_q;

    case (state_q)
      S_IDLE: begin
        bus.operand_rdy = 1'b1;
        if (bus.operand_val) begin
          bus.A_en = 1'b1;
          bus.B_en = 1'b1;
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        if (force_end) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (bus.A_lt_B) begin
          bus.A_en  = 1'b1;
          bus.B_en  = 1'b1;
          bus.A_sel = 2'd1;
          bus.B_sel = 1'b1;
        end else if (!bus.B_zero) begin
          bus.A_en  = 1'b1;
          bus.A_sel = 2'd2;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bus.result_val = 1'b1;
        if (bus.result_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_gcd_ctrl.sv
// Scoreboard bench for gcd_ctrl with a behavioural A/B datapath; expected results are hand-computed.
// Define GCD_CTRL_TIMEOUT_EN to select the MAX_ITER=4 expectation set.
module tb_gcd_ctrl;
`ifdef GCD_CTRL_TIMEOUT_EN
  localparam int TB_MAX_ITER = 4;
`else
  localparam int TB_MAX_ITER = 1024;
`endif

  typedef struct {
    logic [15:0] res;
    logic [15:0] cnt;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] operand_A = '0;
  logic [15:0] operand_B = '0;
  logic [15:0] a_q, b_q;
  logic [15:0] result_data;
  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;

  gcd_ctrl_if #(.CNT_W(16)) bus ();

  gcd_ctrl #(.CNT_W(16), .MAX_ITER(TB_MAX_ITER)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural datapath driven by the controller's enables and selects
  always_ff @(posedge clk) begin
    if (bus.A_en)
      a_q <= (bus.A_sel == 2'd0) ? operand_A : (bus.A_sel == 2'd1) ? b_q : a_q - b_q;
    if (bus.B_en)
      b_q <= bus.B_sel ? a_q : operand_B;
  end
  assign bus.B_zero   = (b_q == 16'd0);
  assign bus.A_lt_B   = (a_q < b_q);
  assign result_data  = a_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per completed result handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.A_sel == 2'd3) begin
        miscompares++;
        $display("FAIL a_sel_3: got 3, expected 0..2 at %0t", $time);
      end
      if (!reset && bus.result_val && bus.result_rdy) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_result: got result %0d, expected none", result_data);
        end else begin
          e = sb.pop_front();
          check("result_data", 32'(result_data), 32'(e.res));
          check("cycle_count", 32'(bus.cycle_count), 32'(e.cnt));
          check("result_err", 32'(bus.result_err), 32'(e.err));
          check("busy_done", 32'(bus.busy), 32'd1);
        end
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] res, input logic [15:0] cnt, input logic err);
    int n = 0;
    exp_t e;
    while (!bus.operand_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.operand_rdy) begin
      vectors++;
      miscompares++;
      $display("FAIL operand_rdy_wait: got 0, expected 1");
    end
    e.res = res; e.cnt = cnt; e.err = err;
    sb.push_back(e);
    operand_A = a;
    operand_B = b;
    bus.operand_val = 1'b1;
    @(posedge clk); #1;
    bus.operand_val = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res, input logic [15:0] cnt, input logic err);
    issue(a, b, res, cnt, err);
    wait_drain();
  endtask

  initial begin
    int n;
    bus.operand_val = 1'b0;
    bus.result_rdy  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_operand_rdy", 32'(bus.operand_rdy), 32'd1);
    check("rst_result_val", 32'(bus.result_val), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_enables", 32'({bus.A_en, bus.B_en}), 32'd0);
    check("rst_sels", 32'({bus.A_sel, bus.B_sel}), 32'd0);
    check("rst_cycle_count", 32'(bus.cycle_count), 32'd0);
    check("rst_result_err", 32'(bus.result_err), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

`ifdef GCD_CTRL_TIMEOUT_EN
    run_op(16'd27, 16'd15, 16'd3, 16'd4, 1'b1);
    run_op(16'd0, 16'd0, 16'd0, 16'd1, 1'b0);
    run_op(16'd0, 16'd5, 16'd5, 16'd2, 1'b0);
    run_op(16'd7, 16'd7, 16'd7, 16'd3, 1'b0);
    run_op(16'd2, 16'd1, 16'd1, 16'd4, 1'b0);
    run_op(16'd100, 16'd75, 16'd50, 16'd4, 1'b1);
    issue(16'd12, 16'd8, 16'd4, 16'd4, 1'b1);
`else
    run_op(16'd27, 16'd15, 16'd3, 16'd10, 1'b0);
    run_op(16'd0, 16'd0, 16'd0, 16'd1, 1'b0);
    run_op(16'd0, 16'd5, 16'd5, 16'd2, 1'b0);
    run_op(16'd7, 16'd7, 16'd7, 16'd3, 1'b0);
    run_op(16'd2, 16'd1, 16'd1, 16'd4, 1'b0);
    run_op(16'd100, 16'd75, 16'd25, 16'd7, 1'b0);
    issue(16'd12, 16'd8, 16'd4, 16'd6, 1'b0);
`endif

    // Result held off by the consumer; operand_val pulses in DONE must be ignored
    bus.result_rdy = 1'b0;
    n = 0;
    while (!bus.result_val && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_reached_done", 32'(bus.result_val), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("hold_result_val", 32'(bus.result_val), 32'd1);
      check("hold_operand_rdy", 32'(bus.operand_rdy), 32'd0);
      operand_A = 16'd99;
      operand_B = 16'd33;
      bus.operand_val = 1'b1;
      @(posedge clk); #1;
    end
    bus.operand_val = 1'b0;
    check("hold_result_data", 32'(result_data), 32'd4);
    bus.result_rdy = 1'b1;
    @(posedge clk); #1;
    check("post_hs_operand_rdy", 32'(bus.operand_rdy), 32'd1);
    check("post_hs_result_val", 32'(bus.result_val), 32'd0);
    wait_drain();

    // Reset during the third CALC cycle of (255,1)
    operand_A = 16'd255;
    operand_B = 16'd1;
    bus.operand_val = 1'b1;
    @(posedge clk); #1;
    bus.operand_val = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_calc_busy", 32'(bus.busy), 32'd1);
    check("mid_calc_count", 32'(bus.cycle_count), 32'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_operand_rdy", 32'(bus.operand_rdy), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_cycle_count", 32'(bus.cycle_count), 32'd0);
    check("abort_enables", 32'({bus.A_en, bus.B_en}), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

`ifdef GCD_CTRL_TIMEOUT_EN
    run_op(16'd9, 16'd6, 16'd3, 16'd4, 1'b1);
    run_op(16'd255, 16'd1, 16'd252, 16'd4, 1'b1);
    run_op(16'd0, 16'd5, 16'd5, 16'd2, 1'b0);
`else
    run_op(16'd9, 16'd6, 16'd3, 16'd6, 1'b0);
    run_op(16'd255, 16'd1, 16'd1, 16'd257, 1'b0);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
